mult_seq: RTL and testbench

Multi-cycle iterative multiplier for the ARM7 datapath. It covers the full ARM multiply group: MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. Width and bits-per-iteration are parameters. Operands are captured on a start/done handshake. The block sits beside the ALU in the execute stage and supersedes the single-cycle combinational 32-bit multiplier, which had no accumulate, no long forms and no flags.

---
 rtl/mult_seq_if.sv | 31 +++
 rtl/mult_seq.sv | 155 +++++++++++++++
 tb/tb_mult_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle for the iterative ARM multiplier.
// The master drives the request and operands; the slave (mult_seq) drives status and results.
interface mult_seq_if #(
   parameter int N = 32
);
   logic         start;
   logic         long_mul;
   logic         signed_op;
   logic         accumulate;
   logic [N-1:0] rm;
   logic [N-1:0] rs;
   logic [N-1:0] rn_lo;
   logic [N-1:0] rn_hi;
   logic         c_in;
   logic         v_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result_lo;
   logic [N-1:0] result_hi;
   logic [3:0]   nzcv;

   modport master (
      output start, long_mul, signed_op, accumulate, rm, rs, rn_lo, rn_hi, c_in, v_in,
      input  busy, done, result_lo, result_hi, nzcv
   );

   modport slave (
      input  start, long_mul, signed_op, accumulate, rm, rs, rn_lo, rn_hi, c_in, v_in,
      output busy, done, result_lo, result_hi, nzcv
   );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle iterative multiplier covering MUL, MLA, UMULL, UMLAL, SMULL and SMLAL.
// Consumes K multiplier bits per cycle on operand magnitudes, then fixes sign and accumulates.
module mult_seq #(
   parameter int N = 32,
   parameter int K = 8
) (
   input logic     clk,
   input logic     reset,
   mult_seq_if.slave bus
);
   localparam int I  = N / K;
   localparam int IW = (I > 1) ? $clog2(I) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic [2*N-1:0]  mcand_q, mcand_d;
   logic [2*N-1:0]  prod_q, prod_d;
   logic [N-1:0]    mplier_q, mplier_d;
   logic [N-1:0]    rnLo_q, rnLo_d;
   logic [N-1:0]    rnHi_q, rnHi_d;
   logic [N-1:0]    resLo_q, resLo_d;
   logic [N-1:0]    resHi_q, resHi_d;
   logic [3:0]      nzcv_q, nzcv_d;
   logic            negate_q, negate_d;
   logic            longMul_q, longMul_d;
   logic            cFlag_q, cFlag_d;
   logic            vFlag_q, vFlag_d;
   logic            done_q, done_d;

   logic            rmNeg, rsNeg;
   logic [N-1:0]    rmMag, rsMag;
   logic [2*N-1:0]  term;
   logic [2*N-1:0]  fixProd;
   logic [2*N-1:0]  sum;

   // Magnitudes are taken only for signed long forms; -0x80..0 stays 0x80..0, read as unsigned 2^(N-1).
   always_comb begin
      rmNeg   = bus.long_mul & bus.signed_op & bus.rm[N-1];
      rsNeg   = bus.long_mul & bus.signed_op & bus.rs[N-1];
      rmMag   = rmNeg ? -bus.rm : bus.rm;
      rsMag   = rsNeg ? -bus.rs : bus.rs;
      term    = mcand_q * {{(2*N-K){1'b0}}, mplier_q[K-1:0]};
      fixProd = negate_q ? -prod_q : prod_q;
      sum     = fixProd + {rnHi_q, rnLo_q};
   end

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      mplier_d  = mplier_q;
      rnLo_d    = rnLo_q;
      rnHi_d    = rnHi_q;
      resLo_d   = resLo_q;
      resHi_d   = resHi_q;
      nzcv_d    = nzcv_q;
      negate_d  = negate_q;
      longMul_d = longMul_q;
      cFlag_d   = cFlag_q;
      vFlag_d   = vFlag_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CALC;
               iter_d    = '0;
               mcand_d   = {{N{1'b0}}, rmMag};
               mplier_d  = rsMag;
               prod_d    = '0;
               negate_d  = rmNeg ^ rsNeg;
               longMul_d = bus.long_mul;
               // A zeroed accumulator makes the FIX add unconditional for every form.
               rnLo_d    = bus.accumulate ? bus.rn_lo : '0;
               rnHi_d    = (bus.accumulate && bus.long_mul) ? bus.rn_hi : '0;
               cFlag_d   = bus.c_in;
               vFlag_d   = bus.v_in;
            end
         end
         CALC: begin
            prod_d   = prod_q + term;
            mcand_d  = mcand_q << K;
            mplier_d = mplier_q >> K;
            iter_d   = iter_q + IW'(1);
            if (iter_q == IW'(I - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            resLo_d = sum[N-1:0];
            if (longMul_q) begin
               resHi_d = sum[2*N-1:N];
               nzcv_d  = {sum[2*N-1], sum == '0, cFlag_q, vFlag_q};
            end else begin
               resHi_d = '0;
               nzcv_d  = {sum[N-1], sum[N-1:0] == '0, cFlag_q, vFlag_q};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         iter_q    <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         mplier_q  <= '0;
         rnLo_q    <= '0;
         rnHi_q    <= '0;
         resLo_q   <= '0;
         resHi_q   <= '0;
         nzcv_q    <= '0;
         negate_q  <= 1'b0;
         longMul_q <= 1'b0;
         cFlag_q   <= 1'b0;
         vFlag_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         mplier_q  <= mplier_d;
         rnLo_q    <= rnLo_d;
         rnHi_q    <= rnHi_d;
         resLo_q   <= resLo_d;
         resHi_q   <= resHi_d;
         nzcv_q    <= nzcv_d;
         negate_q  <= negate_d;
         longMul_q <= longMul_d;
         cFlag_q   <= cFlag_d;
         vFlag_q   <= vFlag_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.result_lo = resLo_q;
   assign bus.result_hi = resHi_q;
   assign bus.nzcv      = nzcv_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomised checks of mult_seq against an arithmetic reference model
// using a scoreboard queue filled at request time and drained on done.
module tb_mult_seq;
   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic [3:0]  nzcv;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   lat;
   logic sawDone;
   exp_t expQ[$];
   exp_t lastExp;

   mult_seq_if #(.N(32)) bus ();

   mult_seq #(.N(32), .K(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference uses native 64-bit signed/unsigned arithmetic rather than iteration.
   function automatic exp_t model(input logic lm, input logic so, input logic ac,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] accLo, input logic [31:0] accHi,
                                  input logic c, input logic v);
      exp_t              e;
      logic [63:0]       p;
      logic signed [63:0] sp;
      logic [31:0]       lo32;
      if (lm) begin
         if (so) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            p  = sp;
         end else begin
            p = {32'h0, a} * {32'h0, b};
         end
         if (ac) p = p + {accHi, accLo};
         e.lo   = p[31:0];
         e.hi   = p[63:32];
         e.nzcv = {p[63], p == 64'h0, c, v};
      end else begin
         lo32   = a * b;
         if (ac) lo32 = lo32 + accLo;
         e.lo   = lo32;
         e.hi   = 32'h0;
         e.nzcv = {lo32[31], lo32 == 32'h0, c, v};
      end
      return e;
   endfunction

   task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one request for a single cycle and records its expected result.
   task automatic applyStimulus(input logic lm, input logic so, input logic ac,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] accLo, input logic [31:0] accHi,
                                input logic c, input logic v);
      bus.long_mul   = lm;
      bus.signed_op  = so;
      bus.accumulate = ac;
      bus.rm         = a;
      bus.rs         = b;
      bus.rn_lo      = accLo;
      bus.rn_hi      = accHi;
      bus.c_in       = c;
      bus.v_in       = v;
      bus.start      = 1'b1;
      expQ.push_back(model(lm, so, ac, a, b, accLo, accHi, c, v));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input int startCycle, output int cycles);
      cycles = startCycle;
      while (bus.done !== 1'b1 && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 20) compare("done_timeout", {63'h0, bus.done}, 64'h1);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      compare({tag, "_sb"}, {63'h0, expQ.size() > 0}, 64'h1);
      if (expQ.size() > 0) begin
         e       = expQ.pop_front();
         lastExp = e;
         compare({tag, "_lo"},   {32'h0, bus.result_lo}, {32'h0, e.lo});
         compare({tag, "_hi"},   {32'h0, bus.result_hi}, {32'h0, e.hi});
         compare({tag, "_nzcv"}, {60'h0, bus.nzcv},      {60'h0, e.nzcv});
         compare({tag, "_busy"}, {63'h0, bus.busy},      64'h0);
      end
   endtask

   task automatic runOp(input string tag, input logic lm, input logic so, input logic ac,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] accLo, input logic [31:0] accHi,
                        input logic c, input logic v);
      int cyc;
      applyStimulus(lm, so, ac, a, b, accLo, accHi, c, v);
      compare({tag, "_busy1"}, {63'h0, bus.busy}, 64'h1);
      waitDone(1, cyc);
      compare({tag, "_lat"}, 64'(cyc), 64'd6);
      checkOutput(tag);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.long_mul   = 1'b0;
      bus.signed_op  = 1'b0;
      bus.accumulate = 1'b0;
      bus.rm         = 32'h0;
      bus.rs         = 32'h0;
      bus.rn_lo      = 32'h0;
      bus.rn_hi      = 32'h0;
      bus.c_in       = 1'b0;
      bus.v_in       = 1'b0;
      repeat (2) @(negedge clk);
      compare("rst_busy", {63'h0, bus.busy}, 64'h0);
      compare("rst_done", {63'h0, bus.done}, 64'h0);
      compare("rst_lo",   {32'h0, bus.result_lo}, 64'h0);
      compare("rst_hi",   {32'h0, bus.result_hi}, 64'h0);
      compare("rst_nzcv", {60'h0, bus.nzcv}, 64'h0);
      reset = 1'b0;
      @(negedge clk);

      runOp("umull",  1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 0);
      compare("umull_const", {bus.result_hi, bus.result_lo}, 64'hFFFFFFFE_00000001);
      compare("umull_flags", {60'h0, bus.nzcv}, 64'hA);
      @(negedge clk);
      runOp("smull",  1, 1, 0, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 0, 1);
      compare("smull_const", {bus.result_hi, bus.result_lo}, 64'h40000000_00000000);
      repeat (3) @(negedge clk);
      compare("hold_lo", {32'h0, bus.result_lo}, {32'h0, lastExp.lo});
      compare("hold_hi", {32'h0, bus.result_hi}, {32'h0, lastExp.hi});
      runOp("smlal",  1, 1, 1, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 0, 0);
      compare("smlal_const", {bus.result_hi, bus.result_lo}, 64'hFFFFFFFF_FFFFFFFA);
      runOp("mla",    0, 0, 1, 32'h3, 32'h5, 32'h7, 32'hDEAD, 0, 0);
      compare("mla_const", {bus.result_hi, bus.result_lo}, 64'h16);
      runOp("mul_z",  0, 1, 0, 32'h10000, 32'h10000, 32'h0, 32'h0, 1, 1);
      compare("mul_z_flags", {60'h0, bus.nzcv}, 64'h7);
      runOp("umlal",  1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0, 0);
      compare("umlal_z", {bus.result_hi, bus.result_lo}, 64'h0);

      // A second start mid-CALC with new operands must not disturb the first operation.
      @(negedge clk);
      applyStimulus(0, 0, 0, 32'h3, 32'h5, 32'h0, 32'h0, 0, 0);
      bus.start = 1'b1;
      bus.rm    = 32'h9;
      bus.rs    = 32'h9;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(2, lat);
      compare("ign_lat", 64'(lat), 64'd6);
      checkOutput("ign");
      applyStimulus(0, 0, 1, 32'h11, 32'h13, 32'h100, 32'h0, 1, 0);
      waitDone(1, lat);
      compare("b2b_lat", 64'(lat), 64'd6);
      checkOutput("b2b");

      // Reset mid-operation, with start held alongside reset.
      applyStimulus(1, 0, 0, 32'h1234, 32'h5678, 32'h0, 32'h0, 1, 1);
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      expQ.delete();
      compare("mid_rst_busy", {63'h0, bus.busy}, 64'h0);
      compare("mid_rst_lo",   {32'h0, bus.result_lo}, 64'h0);
      compare("mid_rst_hi",   {32'h0, bus.result_hi}, 64'h0);
      compare("mid_rst_nzcv", {60'h0, bus.nzcv}, 64'h0);
      sawDone = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
         @(negedge clk);
      end
      compare("mid_rst_quiet", {63'h0, sawDone}, 64'h0);
      runOp("mul2x2", 0, 0, 0, 32'h2, 32'h2, 32'h0, 32'h0, 0, 0);
      compare("mul2x2_const", {32'h0, bus.result_lo}, 64'h4);

      for (int i = 0; i < 8; i++) begin
         runOp("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               $urandom, $urandom, $urandom, $urandom,
               1'($urandom_range(1)), 1'($urandom_range(1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
